enigma_dispatch: RTL and testbench

ENIGMA_DISPATCH -- requirements
Module: enigma_dispatch

---
 rtl/enigma_dispatch.sv | 122 ++++++++++++
 tb/tb_enigma_dispatch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_dispatch.sv
// In-order dispatch queue with per-id in-flight tracking and a minimum hold latency.
// Optional statistics counters are built when ENIGMA_DISPATCH_STAT_EN is defined.
module enigma_dispatch #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_c,
  output logic         ready_c,
  input  logic [127:0] payload_c,
  input  logic [5:0]   id_c,
  input  logic [1:0]   qos_c,
  output logic         conflict_c,
  output logic         release_c,
  output logic [5:0]   releaseid_c,
  output logic         d_valid,
  input  logic         d_ready,
  output logic [127:0] d_payload,
  output logic [5:0]   d_id,
  output logic [1:0]   d_qos,
  output logic [15:0]  stat_accept,
  output logic [15:0]  stat_conflict
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   PTR_ONE = 1;
  localparam logic [15:0]   LAT16   = 16'(LATENCY);

  logic [PW:0]   wr_q, rd_q;
  logic [63:0]   busy_q, busy_d;
  logic [15:0]   tick_q;
  logic          release_q;
  logic [5:0]    releaseid_q;

  logic [127:0]  pl_mem    [DEPTH];
  logic [5:0]    id_mem    [DEPTH];
  logic [1:0]    qos_mem   [DEPTH];
  logic [15:0]   stamp_mem [DEPTH];

  logic          full, empty, accept, drain;
  logic [PW-1:0] head, tail;
  logic [15:0]   age;

  assign head  = rd_q[PW-1:0];
  assign tail  = wr_q[PW-1:0];
  assign full  = (wr_q[PW] != rd_q[PW]) && (tail == head);
  assign empty = (wr_q == rd_q);
  // Modulo-2^16 age keeps eligibility correct across tick wrap.
  assign age   = tick_q - stamp_mem[head];

  assign conflict_c = !rst && valid_c && busy_q[id_c];
  assign ready_c    = !rst && !full && !conflict_c;
  assign d_valid    = !rst && !empty && (age >= LAT16);
  assign accept     = valid_c && ready_c;
  assign drain      = d_valid && d_ready;

  assign d_payload   = pl_mem[head];
  assign d_id        = id_mem[head];
  assign d_qos       = qos_mem[head];
  assign release_c   = release_q;
  assign releaseid_c = releaseid_q;

  always_comb begin
    busy_d = busy_q;
    if (drain)  busy_d[d_id] = 1'b0;
    if (accept) busy_d[id_c] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q        <= '0;
      rd_q        <= '0;
      busy_q      <= '0;
      tick_q      <= '0;
      release_q   <= 1'b0;
      releaseid_q <= '0;
    end else begin
      tick_q    <= tick_q + 16'd1;
      busy_q    <= busy_d;
      release_q <= drain;
      if (accept) wr_q <= wr_q + PTR_ONE;
      if (drain) begin
        rd_q        <= rd_q + PTR_ONE;
        releaseid_q <= d_id;
      end
    end
  end

  // Entry storage carries no reset; validity is governed by the pointers.
  always_ff @(posedge clk) begin
    if (accept) begin
      pl_mem[tail]    <= payload_c;
      id_mem[tail]    <= id_c;
      qos_mem[tail]   <= qos_c;
      stamp_mem[tail] <= tick_q;
    end
  end

`ifdef ENIGMA_DISPATCH_STAT_EN
  logic [15:0] stat_accept_q, stat_conflict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accept_q   <= '0;
      stat_conflict_q <= '0;
    end else begin
      if (accept && stat_accept_q != 16'hFFFF)
        stat_accept_q <= stat_accept_q + 16'd1;
      if (conflict_c && stat_conflict_q != 16'hFFFF)
        stat_conflict_q <= stat_conflict_q + 16'd1;
    end
  end

  assign stat_accept   = stat_accept_q;
  assign stat_conflict = stat_conflict_q;
`else
  assign stat_accept   = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_enigma_dispatch.sv
// Randomized bench for enigma_dispatch against a queue-based reference model.
// Stat expectations follow ENIGMA_DISPATCH_STAT_EN when defined.
module tb_enigma_dispatch;

  localparam int DEPTH = 4;
  localparam int LAT   = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_c = 1'b0;
  logic         ready_c;
  logic [127:0] payload_c = '0;
  logic [5:0]   id_c = '0;
  logic [1:0]   qos_c = '0;
  logic         conflict_c, release_c;
  logic [5:0]   releaseid_c;
  logic         d_valid;
  logic         d_ready = 1'b0;
  logic [127:0] d_payload;
  logic [5:0]   d_id;
  logic [1:0]   d_qos;
  logic [15:0]  stat_accept, stat_conflict;

  enigma_dispatch #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .valid_c(valid_c), .ready_c(ready_c),
    .payload_c(payload_c), .id_c(id_c), .qos_c(qos_c),
    .conflict_c(conflict_c), .release_c(release_c), .releaseid_c(releaseid_c),
    .d_valid(d_valid), .d_ready(d_ready), .d_payload(d_payload),
    .d_id(d_id), .d_qos(d_qos),
    .stat_accept(stat_accept), .stat_conflict(stat_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] pl;
    logic [5:0]   id;
    logic [1:0]   qos;
    int           stamp;
  } ent_t;

  ent_t       mq[$];
  bit         busy[64];
  int         cyc;
  bit         rel_v;
  logic [5:0] rel_id;
  int         st_acc, st_con;
  int         n_checks = 0, n_errors = 0;

  bit         obs_dv, obs_rel, obs_acc;
  logic [5:0] obs_did, obs_relid;
  int         obs_cyc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < 64; i++) busy[i] = 1'b0;
    cyc = 0; rel_v = 1'b0; rel_id = '0; st_acc = 0; st_con = 0;
  endtask

  task automatic step(input bit v, input logic [5:0] id, input bit rdy);
    bit exp_con, exp_rdy, exp_dv, acc, drn;
    ent_t e;
    @(negedge clk);
    valid_c   = v;
    id_c      = id;
    payload_c = {$urandom, $urandom, $urandom, $urandom};
    qos_c     = 2'($urandom);
    d_ready   = rdy;
    #1;
    exp_con = v && busy[id];
    exp_rdy = (mq.size() < DEPTH) && !exp_con;
    exp_dv  = (mq.size() > 0) && ((cyc - mq[0].stamp) >= LAT);
    chk("conflict", conflict_c, exp_con);
    chk("ready", ready_c, exp_rdy);
    chk("d_valid", d_valid, exp_dv);
    if (exp_dv) begin
      chk("d_id", d_id, mq[0].id);
      chk("d_payload", d_payload, mq[0].pl);
      chk("d_qos", d_qos, mq[0].qos);
    end
    chk("release", release_c, rel_v);
    if (rel_v) chk("releaseid", releaseid_c, rel_id);
`ifdef ENIGMA_DISPATCH_STAT_EN
    chk("stat_accept", stat_accept, 16'(st_acc));
    chk("stat_conflict", stat_conflict, 16'(st_con));
`else
    chk("stat_accept", stat_accept, 16'd0);
    chk("stat_conflict", stat_conflict, 16'd0);
`endif
    obs_dv = d_valid; obs_did = d_id; obs_rel = release_c; obs_relid = releaseid_c;
    obs_cyc = cyc; obs_acc = valid_c && ready_c;
    acc = v && exp_rdy;
    drn = exp_dv && rdy;
    if (drn) begin
      busy[mq[0].id] = 1'b0;
      rel_v  = 1'b1;
      rel_id = mq[0].id;
      void'(mq.pop_front());
    end else begin
      rel_v = 1'b0;
    end
    if (acc) begin
      e.pl = payload_c; e.id = id; e.qos = qos_c; e.stamp = cyc;
      mq.push_back(e);
      busy[id] = 1'b1;
      if (st_acc < 65535) st_acc++;
    end
    if (exp_con && st_con < 65535) st_con++;
    cyc++;
  endtask

  // Idle cycles with an empty queue; nothing can change but the tick.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_c = 1'b0;
      d_ready = 1'b1;
      rel_v   = 1'b0;
      cyc++;
    end
  endtask

  task automatic do_reset(input logic [5:0] probe_id);
    @(negedge clk);
    rst = 1'b1; valid_c = 1'b0; d_ready = 1'b0;
    @(posedge clk);
    #1;
    valid_c = 1'b1; id_c = probe_id;
    #1;
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_release", release_c, 1'b0);
    chk("rst_releaseid", releaseid_c, 6'd0);
    chk("rst_conflict", conflict_c, 1'b0);
    chk("rst_stat_accept", stat_accept, 16'd0);
    chk("rst_stat_conflict", stat_conflict, 16'd0);
    rst = 1'b0; valid_c = 1'b0;
    model_clear();
  endtask

  int rise;

  initial begin
    model_clear();
    do_reset(6'd0);

    // Accept id 5 at cycle 10: d_valid at 18, release at 19.
    idle(10);
    step(1'b1, 6'd5, 1'b1);
    chk("acc_cycle10", obs_acc, 1'b1);
    rise = -1;
    for (int i = 0; i < 20 && rise < 0; i++) begin
      step(1'b0, 6'd0, 1'b1);
      if (obs_dv) rise = obs_cyc;
    end
    chk("rise_cycle", 32'(rise), 32'd18);
    step(1'b0, 6'd0, 1'b1);
    chk("rel_cycle19", obs_rel, 1'b1);
    chk("rel_id5", obs_relid, 6'd5);

    // Conflict on in-flight id 5, then id 6 accepted.
    do_reset(6'd5);
    step(1'b1, 6'd5, 1'b0);
    step(1'b1, 6'd5, 1'b0);
    step(1'b1, 6'd6, 1'b0);
    step(1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 6'd0, 1'b1);

    // Fill with ids 0..4, id 4 refused, then drain in order.
    do_reset(6'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 6'(i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 6'd4, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 6'd0, 1'b1);

    // Full with eligible head: id 9 refused on the drain cycle, accepted next.
    do_reset(6'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 6'(20 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 6'd0, 1'b0);
    step(1'b1, 6'd9, 1'b1);
    chk("full_drain_no_acc", obs_acc, 1'b0);
    step(1'b1, 6'd9, 1'b0);
    chk("acc_after_drain", obs_acc, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 6'd0, 1'b1);

    // Randomized traffic over a small id range to provoke conflicts.
    do_reset(6'd0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 60, 6'($urandom_range(0, 11)), $urandom_range(0, 99) < 45);
    for (int i = 0; i < 60; i++) step(1'b0, 6'd0, 1'b1);

    // Reset with three in flight; an old id must be accepted afterwards.
    do_reset(6'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 6'(30 + i), 1'b0);
    do_reset(6'd31);
    step(1'b1, 6'd31, 1'b0);
    chk("reaccept_old_id", obs_acc, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 6'd0, 1'b1);

    // Accept at tick FFFC; eligibility must survive the tick wrap.
    do_reset(6'd0);
    idle(65532);
    step(1'b1, 6'd7, 1'b0);
    chk("wrap_acc", obs_acc, 1'b1);
    rise = -1;
    for (int i = 0; i < 20 && rise < 0; i++) begin
      step(1'b0, 6'd0, 1'b1);
      if (obs_dv) rise = obs_cyc;
    end
    chk("wrap_rise_tick", 16'(rise), 16'h0004);
    step(1'b0, 6'd0, 1'b1);
    chk("wrap_rel_id", obs_relid, 6'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
